// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types, header defaults and ASCII fold for the pool datapath
package pool_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, LINK, LEN, NAME, DONE} find_st_t;

    typedef enum logic [1:0] {OP_NOP, OP_RD, OP_WR, OP_FIND} pool_ops_t;
    typedef enum logic [1:0] {STS_OK, STS_BUSY, STS_ERR} pool_sts_t;

    localparam int         LBYTES_DEF  = 2;
    localparam logic [7:0] LMASK_DEF   = 8'h1f;
    localparam int         IMM_BIT_DEF = 7;

    // End of list is an all-ones link over the full link field width.
    function automatic logic [63:0] end_link_val(input int bits);
        return (64'd1 << bits) - 64'd1;
    endfunction

    function automatic logic [7:0] fold_ascii(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7a) ? (c - 8'h20) : c;
    endfunction

endpackage

// File: rtl/tib_cache.sv
// rtl/tib_cache.sv - token buffer: sequential write pointer, indexed read, optional case fold
module tib_cache
    import pool_pkg::*;
#(
    parameter int NMAX   = 31,
    parameter int DSZ    = 8,
    parameter int IW     = 5,
    parameter int CASE_I = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           we,
    input  logic [DSZ-1:0] wdata,
    input  logic [IW-1:0]  ridx,
    output logic [DSZ-1:0] rdata
);

    logic [DSZ-1:0] buf_q [NMAX];
    logic [IW-1:0]  wptr;
    logic [DSZ-1:0] wd;

    always_comb begin
        wd = wdata;
        if (CASE_I != 0) wd[7:0] = fold_ascii(wdata[7:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      wptr <= '0;
        else if (clr)  wptr <= '0;
        else if (we)   wptr <= wptr + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (we) buf_q[wptr] <= wd;
    end

    assign rdata = buf_q[ridx];

endmodule

// File: rtl/pool_find.sv
// rtl/pool_find.sv - dictionary FIND engine walking the linked word list over a shared byte memory
module pool_find
    import pool_pkg::*;
#(
    parameter int              ASZ     = 17,
    parameter int              DSZ     = 8,
    parameter int              LBYTES  = LBYTES_DEF,
    parameter int              NMAX    = 31,
    parameter logic [DSZ-1:0]  LMASK   = DSZ'(LMASK_DEF),
    parameter int              IMM_BIT = IMM_BIT_DEF,
    parameter int              CASE_I  = 0,
    parameter int              HMAX    = 1023,
    parameter logic [ASZ-1:0]  CTX0    = 'h2b
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ASZ-1:0]             tib_a,
    input  logic [7:0]                 tib_len,
    input  logic                       ctx_we,
    input  logic [ASZ-1:0]             ctx_i,
    output logic [ASZ-1:0]             mem_a,
    input  logic [DSZ-1:0]             mem_vo,
    output logic                       bsy,
    output logic                       done,
    output logic                       hit,
    output logic                       imm,
    output logic [ASZ-1:0]             nfa,
    output logic [ASZ-1:0]             pfa,
    output logic [$clog2(HMAX+1)-1:0]  hops,
    output logic                       err
);

    localparam int              HSZ      = $clog2(HMAX + 1);
    localparam int              LW       = LBYTES * DSZ;
    localparam int              CW       = (ASZ < LW) ? ASZ : LW;
    localparam int              IW       = $clog2(NMAX + 1);
    localparam logic [LW-1:0]   END_LINK = LW'(end_link_val(LW));

    find_st_t       st, st_nx;
    logic [ASZ-1:0] ctx, tib_s, hdr, base, link_a;
    logic [7:0]     tlen, ic, rc, n_rd;
    logic [LW-1:0]  link;
    logic [DSZ-1:0] cmp_b, cache_b;
    logic           wimm, rd_v1, rd_v2;
    logic           accept, bad, issue, last, len_ok, name_ok;
    logic           next_word, set_hit, set_err;

    tib_cache #(.NMAX(NMAX), .DSZ(DSZ), .IW(IW), .CASE_I(CASE_I)) u_cache (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .we    (st == LOAD && rd_v2),
        .wdata (mem_vo),
        .ridx  (rc[IW-1:0]),
        .rdata (cache_b)
    );

    // Every state streams n_rd bytes from base: rd_v1 marks an address on mem_a,
    // rd_v2 marks the matching byte on mem_vo; state changes flush both.
    always_comb begin
        bad     = (tib_len == 8'd0) || (tib_len > 8'(NMAX));
        accept  = (st == IDLE) && start;
        link_a  = ASZ'(link[CW-1:0]);
        cmp_b   = mem_vo;
        if (CASE_I != 0) cmp_b[7:0] = fold_ascii(mem_vo[7:0]);
        len_ok  = (mem_vo & LMASK) == DSZ'(tlen);
        name_ok = (cmp_b == cache_b);
        n_rd    = '0;
        base    = hdr;
        case (st)
            LOAD:    begin n_rd = tlen;       base = tib_s; end
            LINK:    begin n_rd = 8'(LBYTES); base = hdr; end
            LEN:     begin n_rd = 8'd1;       base = hdr + ASZ'(LBYTES); end
            NAME:    begin n_rd = tlen;       base = hdr + ASZ'(LBYTES + 1); end
            default: ;
        endcase
        issue     = (ic < n_rd);
        last      = rd_v2 && (rc == n_rd - 8'd1);
        next_word = 1'b0;
        set_hit   = 1'b0;
        set_err   = 1'b0;
        st_nx     = st;
        case (st)
            IDLE: if (start) begin
                st_nx   = bad ? DONE : LOAD;
                set_err = bad;
            end
            LOAD: if (last) st_nx = LINK;
            LINK: if (last) st_nx = LEN;
            LEN:  if (rd_v2) begin
                if (len_ok) st_nx = NAME;
                else        next_word = 1'b1;
            end
            NAME: if (rd_v2) begin
                if (!name_ok)  next_word = 1'b1;
                else if (last) begin
                    st_nx   = DONE;
                    set_hit = 1'b1;
                end
            end
            DONE:    st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
        if (next_word) begin
            if (link == END_LINK)            st_nx = DONE;
            else if (hops == HSZ'(HMAX)) begin
                st_nx   = DONE;
                set_err = 1'b1;
            end
            else                              st_nx = LINK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st    <= IDLE;
            ctx   <= CTX0;
            hit   <= 1'b0;
            imm   <= 1'b0;
            err   <= 1'b0;
            nfa   <= '0;
            pfa   <= '0;
            hops  <= '0;
            mem_a <= '0;
            tib_s <= '0;
            hdr   <= '0;
            tlen  <= '0;
            link  <= '0;
            wimm  <= 1'b0;
            ic    <= '0;
            rc    <= '0;
            rd_v1 <= 1'b0;
            rd_v2 <= 1'b0;
        end else begin
            st <= st_nx;
            if (ctx_we) ctx <= ctx_i;
            if (accept) begin
                hit <= 1'b0;
                err <= 1'b0;
                if (!bad) begin
                    tib_s <= tib_a;
                    tlen  <= tib_len;
                    hdr   <= ctx;
                    hops  <= '0;
                end
            end
            if (set_err) err <= 1'b1;
            if (st_nx == LINK && st != LINK) begin
                hops <= hops + HSZ'(1);
                if (next_word) hdr <= link_a;
            end
            if (st == LINK && rd_v2) link[int'(rc)*DSZ +: DSZ] <= mem_vo;
            if (st == LEN && rd_v2)  wimm <= mem_vo[IMM_BIT];
            if (set_hit) begin
                hit <= 1'b1;
                imm <= wimm;
                nfa <= hdr;
                pfa <= hdr + ASZ'(LBYTES + 1) + ASZ'(tlen);
            end
            if (st_nx != st) begin
                ic    <= '0;
                rc    <= '0;
                rd_v1 <= 1'b0;
                rd_v2 <= 1'b0;
            end else begin
                rd_v2 <= rd_v1;
                if (rd_v2) rc <= rc + 8'd1;
                if (issue) begin
                    mem_a <= base + ASZ'(ic);
                    ic    <= ic + 8'd1;
                    rd_v1 <= 1'b1;
                end else begin
                    rd_v1 <= 1'b0;
                end
            end
        end
    end

    assign done = (st == DONE);
    assign bsy  = (st == LOAD) || (st == LINK) || (st == LEN) || (st == NAME);

endmodule

// File: tb/tb_pool_find.sv
// tb/tb_pool_find.sv - scoreboard bench for pool_find across case-sensitive, case-folding and short-hop-limit builds
module tb_pool_find;

    localparam int ASZ = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [2:0]     start;
    logic [ASZ-1:0] tib_a, ctx_i;
    logic [7:0]     tib_len;
    logic           ctx_we;
    logic [ASZ-1:0] mem_a_w [3];
    logic [7:0]     vo [3];
    logic           bsy_w [3], done_w [3], hit_w [3], imm_w [3], err_w [3];
    logic [ASZ-1:0] nfa_w [3], pfa_w [3];
    logic [9:0]     hops0, hops1, hops_w [3];
    logic [3:0]     hops2;
    logic [7:0]     mem [0:(1<<ASZ)-1];

    int n_checks = 0;
    int n_fail   = 0;
    int mac0     = 0;
    int bad_a    = 0;
    bit mon_on   = 1'b0;

    typedef struct {
        int             dut;
        logic           hit;
        logic           err;
        logic [9:0]     hops;
        logic           imm;
        logic [ASZ-1:0] nfa;
        logic [ASZ-1:0] pfa;
    } exp_t;
    exp_t sbq [$];

    pool_find u0 (.clk(clk), .rst(rst), .start(start[0]), .tib_a(tib_a), .tib_len(tib_len),
        .ctx_we(ctx_we), .ctx_i(ctx_i), .mem_a(mem_a_w[0]), .mem_vo(vo[0]), .bsy(bsy_w[0]),
        .done(done_w[0]), .hit(hit_w[0]), .imm(imm_w[0]), .nfa(nfa_w[0]), .pfa(pfa_w[0]),
        .hops(hops0), .err(err_w[0]));
    pool_find #(.CASE_I(1)) u1 (.clk(clk), .rst(rst), .start(start[1]), .tib_a(tib_a), .tib_len(tib_len),
        .ctx_we(ctx_we), .ctx_i(ctx_i), .mem_a(mem_a_w[1]), .mem_vo(vo[1]), .bsy(bsy_w[1]),
        .done(done_w[1]), .hit(hit_w[1]), .imm(imm_w[1]), .nfa(nfa_w[1]), .pfa(pfa_w[1]),
        .hops(hops1), .err(err_w[1]));
    pool_find #(.HMAX(8)) u2 (.clk(clk), .rst(rst), .start(start[2]), .tib_a(tib_a), .tib_len(tib_len),
        .ctx_we(ctx_we), .ctx_i(ctx_i), .mem_a(mem_a_w[2]), .mem_vo(vo[2]), .bsy(bsy_w[2]),
        .done(done_w[2]), .hit(hit_w[2]), .imm(imm_w[2]), .nfa(nfa_w[2]), .pfa(pfa_w[2]),
        .hops(hops2), .err(err_w[2]));

    always_comb begin
        hops_w[0] = hops0;
        hops_w[1] = hops1;
        hops_w[2] = {6'd0, hops2};
    end

    always @(posedge clk) for (int i = 0; i < 3; i++) vo[i] <= mem[mem_a_w[i]];
    always @(mem_a_w[0]) mac0++;
    always @(negedge clk) if (mon_on && mem_a_w[0] >= 17'h113 && mem_a_w[0] <= 17'h116) bad_a++;

    task automatic launch(input int d, input logic [ASZ-1:0] a, input logic [7:0] len);
        @(posedge clk); #1;
        tib_a    = a;
        tib_len  = len;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_w[d]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({bsy_w[d], done_w[d], hit_w[d], imm_w[d], err_w[d], nfa_w[d], pfa_w[d], hops_w[d], mem_a_w[d]} !== 0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: bsy=%0b done=%0b hit=%0b imm=%0b err=%0b nfa=%h pfa=%h hops=%0d mem_a=%h, want all zero",
                    d, bsy_w[d], done_w[d], hit_w[d], imm_w[d], err_w[d], nfa_w[d], pfa_w[d], hops_w[d], mem_a_w[d]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        exp_t e; bit ok;
        @(posedge clk); #1;
        ctx_we = 1'b1; ctx_i = 17'h110;
        @(posedge clk); #1;
        ctx_we = 1'b0;
        sbq.push_back('{0, 1'b1, 1'b0, 10'd2, 1'b0, 17'h100, 17'h106});
        launch(0, 17'h800, 8'd3);
        wait_done(0, 2000, ok);
        e = sbq.pop_front();
        n_checks++;
        if (!ok || hit_w[e.dut] !== e.hit || err_w[e.dut] !== e.err || hops_w[e.dut] !== e.hops) begin
            n_fail++;
            $display("FAIL basic_status: done=%0b hit=%0b err=%0b hops=%0d, want done=1 hit=%0b err=%0b hops=%0d",
                ok, hit_w[e.dut], err_w[e.dut], hops_w[e.dut], e.hit, e.err, e.hops);
        end
        n_checks++;
        if ({imm_w[e.dut], nfa_w[e.dut], pfa_w[e.dut]} !== {e.imm, e.nfa, e.pfa}) begin
            n_fail++;
            $display("FAIL basic_addr: imm=%0b nfa=%h pfa=%h, want imm=%0b nfa=%h pfa=%h",
                imm_w[e.dut], nfa_w[e.dut], pfa_w[e.dut], e.imm, e.nfa, e.pfa);
        end
    endtask

    task automatic test_case_fold();
        exp_t e; bit ok;
        sbq.push_back('{0, 1'b0, 1'b0, 10'd2, 1'b0, 17'h0, 17'h0});
        launch(0, 17'h810, 8'd3);
        wait_done(0, 2000, ok);
        e = sbq.pop_front();
        n_checks++;
        if (!ok || hit_w[e.dut] !== e.hit || err_w[e.dut] !== e.err || hops_w[e.dut] !== e.hops) begin
            n_fail++;
            $display("FAIL case_sensitive_status: done=%0b hit=%0b err=%0b hops=%0d, want done=1 hit=%0b err=%0b hops=%0d",
                ok, hit_w[e.dut], err_w[e.dut], hops_w[e.dut], e.hit, e.err, e.hops);
        end
        for (int t = 0; t < 2; t++) begin
            sbq.push_back('{1, 1'b1, 1'b0, 10'd2, 1'b0, 17'h100, 17'h106});
            launch(1, (t == 0) ? 17'h810 : 17'h800, 8'd3);
            wait_done(1, 2000, ok);
            e = sbq.pop_front();
            n_checks++;
            if (!ok || hit_w[e.dut] !== e.hit || err_w[e.dut] !== e.err || hops_w[e.dut] !== e.hops) begin
                n_fail++;
                $display("FAIL case_fold_status%0d: done=%0b hit=%0b err=%0b hops=%0d, want done=1 hit=%0b err=%0b hops=%0d",
                    t, ok, hit_w[e.dut], err_w[e.dut], hops_w[e.dut], e.hit, e.err, e.hops);
            end
            n_checks++;
            if ({nfa_w[e.dut], pfa_w[e.dut]} !== {e.nfa, e.pfa}) begin
                n_fail++;
                $display("FAIL case_fold_addr%0d: nfa=%h pfa=%h, want nfa=%h pfa=%h",
                    t, nfa_w[e.dut], pfa_w[e.dut], e.nfa, e.pfa);
            end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e; bit ok; int extra;
        sbq.push_back('{0, 1'b1, 1'b0, 10'd2, 1'b0, 17'h100, 17'h106});
        launch(0, 17'h800, 8'd3);
        @(posedge clk); #1;
        tib_len = 8'd0; tib_a = 17'h830; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_done(0, 2000, ok);
        e = sbq.pop_front();
        n_checks++;
        if (!ok || hit_w[e.dut] !== e.hit || err_w[e.dut] !== e.err || nfa_w[e.dut] !== e.nfa) begin
            n_fail++;
            $display("FAIL busy_ignore_result: done=%0b hit=%0b err=%0b nfa=%h, want done=1 hit=%0b err=%0b nfa=%h",
                ok, hit_w[e.dut], err_w[e.dut], nfa_w[e.dut], e.hit, e.err, e.nfa);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_w[0]) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL busy_ignore_second_done: extra done cycles=%0d, want 0", extra);
        end
    endtask

    task automatic test_bad_len();
        exp_t e; bit ok;
        logic [7:0] lens [2];
        lens[0] = 8'd0;
        lens[1] = 8'd32;
        for (int t = 0; t < 2; t++) begin
            sbq.push_back('{0, 1'b0, 1'b1, 10'd0, 1'b0, 17'h0, 17'h0});
            mac0 = 0;
            launch(0, 17'h800, lens[t]);
            wait_done(0, 1, ok);
            e = sbq.pop_front();
            n_checks++;
            if (!ok || hit_w[e.dut] !== e.hit || err_w[e.dut] !== e.err) begin
                n_fail++;
                $display("FAIL bad_len_%0d: done_next_cycle=%0b hit=%0b err=%0b, want done_next_cycle=1 hit=%0b err=%0b",
                    lens[t], ok, hit_w[e.dut], err_w[e.dut], e.hit, e.err);
            end
            n_checks++;
            if (mac0 !== 0) begin
                n_fail++;
                $display("FAIL bad_len_mem_%0d: mem_a changes=%0d, want 0", lens[t], mac0);
            end
        end
    endtask

    task automatic test_imm_reject();
        exp_t e; bit ok;
        mem[17'h102] = 8'h83;
        sbq.push_back('{0, 1'b1, 1'b0, 10'd2, 1'b1, 17'h100, 17'h106});
        launch(0, 17'h800, 8'd3);
        wait_done(0, 2000, ok);
        e = sbq.pop_front();
        n_checks++;
        if (!ok || {hit_w[e.dut], imm_w[e.dut], err_w[e.dut], pfa_w[e.dut]} !== {e.hit, e.imm, e.err, e.pfa}) begin
            n_fail++;
            $display("FAIL imm_hit: done=%0b hit=%0b imm=%0b err=%0b pfa=%h, want done=1 hit=%0b imm=%0b err=%0b pfa=%h",
                ok, hit_w[e.dut], imm_w[e.dut], err_w[e.dut], pfa_w[e.dut], e.hit, e.imm, e.err, e.pfa);
        end
        sbq.push_back('{0, 1'b0, 1'b0, 10'd2, 1'b0, 17'h0, 17'h0});
        bad_a  = 0;
        mon_on = 1'b1;
        launch(0, 17'h820, 8'd3);
        wait_done(0, 2000, ok);
        mon_on = 1'b0;
        e = sbq.pop_front();
        n_checks++;
        if (!ok || hit_w[e.dut] !== e.hit || err_w[e.dut] !== e.err || hops_w[e.dut] !== e.hops) begin
            n_fail++;
            $display("FAIL len_reject_status: done=%0b hit=%0b err=%0b hops=%0d, want done=1 hit=%0b err=%0b hops=%0d",
                ok, hit_w[e.dut], err_w[e.dut], hops_w[e.dut], e.hit, e.err, e.hops);
        end
        n_checks++;
        if (bad_a !== 0) begin
            n_fail++;
            $display("FAIL len_reject_name_reads: cycles at 113..116=%0d, want 0", bad_a);
        end
    endtask

    task automatic test_hop_limit();
        exp_t e; bit ok;
        mem[17'h100] = 8'h10;
        mem[17'h101] = 8'h01;
        sbq.push_back('{2, 1'b0, 1'b1, 10'd8, 1'b0, 17'h0, 17'h0});
        launch(2, 17'h830, 8'd3);
        wait_done(2, 2000, ok);
        e = sbq.pop_front();
        n_checks++;
        if (!ok || hit_w[e.dut] !== e.hit || err_w[e.dut] !== e.err || hops_w[e.dut] !== e.hops) begin
            n_fail++;
            $display("FAIL hop_limit: done=%0b hit=%0b err=%0b hops=%0d, want done=1 hit=%0b err=%0b hops=%0d",
                ok, hit_w[e.dut], err_w[e.dut], hops_w[e.dut], e.hit, e.err, e.hops);
        end
        mem[17'h100] = 8'hff;
        mem[17'h101] = 8'hff;
    endtask

    task automatic test_reset_mid();
        exp_t e; bit ok; int seen;
        sbq.push_back('{0, 1'b1, 1'b0, 10'd2, 1'b1, 17'h100, 17'h106});
        launch(0, 17'h800, 8'd3);
        @(negedge clk);
        n_checks++;
        if (bsy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy: bsy=%0b, want 1", bsy_w[0]);
        end
        rst = 1'b0;
        sbq.delete();
        #1;
        n_checks++;
        if ({bsy_w[0], done_w[0], hit_w[0], imm_w[0], err_w[0], nfa_w[0], pfa_w[0], hops_w[0], mem_a_w[0]} !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: bsy=%0b done=%0b hit=%0b imm=%0b err=%0b nfa=%h pfa=%h hops=%0d mem_a=%h, want all zero",
                bsy_w[0], done_w[0], hit_w[0], imm_w[0], err_w[0], nfa_w[0], pfa_w[0], hops_w[0], mem_a_w[0]);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_w[0]) seen++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done_w[0]) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: done cycles=%0d, want 0", seen);
        end
        sbq.push_back('{0, 1'b1, 1'b0, 10'd1, 1'b0, 17'h02b, 17'h031});
        launch(0, 17'h800, 8'd3);
        wait_done(0, 2000, ok);
        e = sbq.pop_front();
        n_checks++;
        if (!ok || hit_w[e.dut] !== e.hit || err_w[e.dut] !== e.err || hops_w[e.dut] !== e.hops) begin
            n_fail++;
            $display("FAIL reset_mid_resume_status: done=%0b hit=%0b err=%0b hops=%0d, want done=1 hit=%0b err=%0b hops=%0d",
                ok, hit_w[e.dut], err_w[e.dut], hops_w[e.dut], e.hit, e.err, e.hops);
        end
        n_checks++;
        if ({imm_w[e.dut], nfa_w[e.dut], pfa_w[e.dut]} !== {e.imm, e.nfa, e.pfa}) begin
            n_fail++;
            $display("FAIL reset_mid_resume_addr: imm=%0b nfa=%h pfa=%h, want imm=%0b nfa=%h pfa=%h",
                imm_w[e.dut], nfa_w[e.dut], pfa_w[e.dut], e.imm, e.nfa, e.pfa);
        end
    endtask

    task automatic load_mem();
        logic [7:0] w_dup  [6];
        logic [7:0] w_drop [7];
        logic [7:0] toks   [12];
        for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'h00;
        w_dup  = '{8'hff, 8'hff, 8'h03, "D", "U", "P"};
        w_drop = '{8'h00, 8'h01, 8'h04, "D", "R", "O", "P"};
        toks   = '{"D", "U", "P", "d", "u", "p", "D", "R", "O", "X", "Y", "Z"};
        for (int i = 0; i < 6; i++) begin
            mem[17'h100 + i] = w_dup[i];
            mem[17'h02b + i] = w_dup[i];
        end
        for (int i = 0; i < 7; i++) mem[17'h110 + i] = w_drop[i];
        for (int i = 0; i < 12; i++) mem[17'h800 + 16 * (i / 3) + (i % 3)] = toks[i];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = '0; tib_a = '0; tib_len = '0; ctx_we = 1'b0; ctx_i = '0;
        load_mem();
        test_reset();
        test_basic();
        test_case_fold();
        test_busy_ignore();
        test_bad_len();
        test_imm_reject();
        test_hop_limit();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
